// File: rtl/lc3_mem_pkg.sv
// Shared types and memory-mapped I/O constants for the LC-3 memory responder.
package lc3_mem_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_e;

  localparam logic [15:0] DSR_ADDR  = 16'hFE04;
  localparam logic [15:0] DDR_ADDR  = 16'hFE06;
  localparam logic [15:0] DSR_READY = 16'h8000;

endpackage

// File: rtl/lc3_ram_sp.sv
// Single-port RAM: synchronous write, synchronous read, one access per cycle, no reset.
module lc3_ram_sp #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 16
) (
  input  logic              Clk,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] ram_q [2**ADDR_W];
  logic [DATA_W-1:0] rdata_q;

  // Read register only loads on reads so it holds across writes.
  always_ff @(posedge Clk) begin
    if (en) begin
      if (we) begin
        ram_q[addr] <= wdata;
      end else begin
        rdata_q <= ram_q[addr];
      end
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/lc3_mem_responder.sv
// LC-3 memory-side responder: wait-state insertion, RAM backing store and
// DSR/DDR display registers, completing each request with a one-cycle ready.
import lc3_mem_pkg::*;

module lc3_mem_responder #(
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned WAIT_CYCLES = 3
) (
  input  logic        Clk,
  input  logic        reset,
  input  logic        mem_en,
  input  logic        we,
  input  logic [15:0] addr,
  input  logic [15:0] wdata,
  output logic [15:0] rdata,
  output logic        ready,
  output logic        busy,
  output logic        disp_valid,
  output logic [15:0] disp_data
);

  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES == 0) ? '0 : 4'(WAIT_CYCLES - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic        ready_q, ready_d;
  logic        disp_valid_q, disp_valid_d;
  logic [15:0] ddr_q, ddr_d;
  logic [15:0] io_rdata_q, io_rdata_d;
  logic        rd_ram_q, rd_ram_d;

  logic        op_we;
  logic [15:0] op_addr;
  logic [15:0] op_wdata;
  logic        is_dsr, is_ddr, complete, ram_en;
  logic [15:0] ram_rdata;

  always_comb begin
    // Live inputs in IDLE so a zero-wait request completes on its accept edge.
    op_we    = (state_q == IDLE) ? we    : we_q;
    op_addr  = (state_q == IDLE) ? addr  : addr_q;
    op_wdata = (state_q == IDLE) ? wdata : wdata_q;
    is_dsr   = (op_addr == DSR_ADDR);
    is_ddr   = (op_addr == DDR_ADDR);

    complete     = 1'b0;
    state_d      = state_q;
    cnt_d        = cnt_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    ready_d      = 1'b0;
    disp_valid_d = 1'b0;
    ddr_d        = ddr_q;
    io_rdata_d   = io_rdata_q;
    rd_ram_d     = rd_ram_q;

    case (state_q)
      IDLE: begin
        if (mem_en) begin
          we_d    = we;
          addr_d  = addr;
          wdata_d = wdata;
          if (WAIT_CYCLES == 0) begin
            complete = 1'b1;
          end else begin
            cnt_d   = CNT_INIT;
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          complete = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (complete) begin
      ready_d = 1'b1;
      if (op_we) begin
        if (is_ddr) begin
          ddr_d        = op_wdata;
          disp_valid_d = 1'b1;
        end
      end else begin
        // rdata source is chosen per read; RAM output register holds otherwise.
        rd_ram_d = !(is_dsr || is_ddr);
        if (is_dsr) begin
          io_rdata_d = DSR_READY;
        end else if (is_ddr) begin
          io_rdata_d = ddr_q;
        end
      end
    end

    ram_en = complete && !is_dsr && !is_ddr;
  end

  always_ff @(posedge Clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      ready_q      <= 1'b0;
      disp_valid_q <= 1'b0;
      ddr_q        <= '0;
      io_rdata_q   <= '0;
      rd_ram_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      ready_q      <= ready_d;
      disp_valid_q <= disp_valid_d;
      ddr_q        <= ddr_d;
      io_rdata_q   <= io_rdata_d;
      rd_ram_q     <= rd_ram_d;
    end
  end

  lc3_ram_sp #(
    .ADDR_W(ADDR_W),
    .DATA_W(16)
  ) u_ram (
    .Clk  (Clk),
    .en   (ram_en),
    .we   (op_we),
    .addr (op_addr[ADDR_W-1:0]),
    .wdata(op_wdata),
    .rdata(ram_rdata)
  );

  assign rdata      = rd_ram_q ? ram_rdata : io_rdata_q;
  assign ready      = ready_q;
  assign busy       = (state_q == WAIT);
  assign disp_valid = disp_valid_q;
  assign disp_data  = ddr_q;

endmodule

// File: tb/tb_lc3_mem_responder.sv
// Scoreboard bench for lc3_mem_responder: two instances (3 and 0 wait states)
// checked cycle by cycle against an address-level memory model.
module tb_lc3_mem_responder;

  localparam int WC [2] = '{3, 0};
  localparam int AW [2] = '{10, 6};

  typedef struct {
    bit          we;
    logic [15:0] addr;
    logic [15:0] wdata;
    int          acc;
    int          due;
  } exp_t;

  logic        Clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_en_i [2];
  logic        we_i     [2];
  logic [15:0] addr_i   [2];
  logic [15:0] wdata_i  [2];
  logic [15:0] rdata_o  [2];
  logic        ready_o  [2];
  logic        busy_o   [2];
  logic        dv_o     [2];
  logic [15:0] dd_o     [2];

  int          cyc = 0;
  int          n_vec = 0;
  int          n_err = 0;

  exp_t        q [2][$];
  logic [15:0] mem_m [int];
  logic [15:0] ddr_m   [2];
  logic [15:0] last_rd [2];
  bit          rd_known [2];
  logic [15:0] wl [2][$];

  lc3_mem_responder #(.ADDR_W(10), .WAIT_CYCLES(3)) dut_w3 (
    .Clk(Clk), .reset(reset), .mem_en(mem_en_i[0]), .we(we_i[0]),
    .addr(addr_i[0]), .wdata(wdata_i[0]), .rdata(rdata_o[0]), .ready(ready_o[0]),
    .busy(busy_o[0]), .disp_valid(dv_o[0]), .disp_data(dd_o[0])
  );

  lc3_mem_responder #(.ADDR_W(6), .WAIT_CYCLES(0)) dut_w0 (
    .Clk(Clk), .reset(reset), .mem_en(mem_en_i[1]), .we(we_i[1]),
    .addr(addr_i[1]), .wdata(wdata_i[1]), .rdata(rdata_o[1]), .ready(ready_o[1]),
    .busy(busy_o[1]), .disp_valid(dv_o[1]), .disp_data(dd_o[1])
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  function automatic void chk(string nm, int d, logic [15:0] act, logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s dut%0d cyc=%0d: got %h, expected %h", nm, d, cyc, act, exp);
    end
  endfunction

  // Pop any response due this cycle, apply it to the model, compare all outputs.
  task automatic check_dut(int d);
    exp_t        e;
    bit          exp_ready = 1'b0;
    bit          exp_dv = 1'b0;
    bit          exp_busy;
    int          key;
    exp_busy = (q[d].size() > 0) && (cyc >= q[d][0].acc) && (cyc < q[d][0].due);
    if (q[d].size() > 0 && cyc >= q[d][0].due) begin
      e = q[d].pop_front();
      exp_ready = 1'b1;
      key = (d << 16) | (int'(e.addr) & ((1 << AW[d]) - 1));
      if (e.addr == 16'hFE04) begin
        if (!e.we) begin last_rd[d] = 16'h8000; rd_known[d] = 1'b1; end
      end else if (e.addr == 16'hFE06) begin
        if (e.we) begin ddr_m[d] = e.wdata; exp_dv = 1'b1; end
        else begin last_rd[d] = ddr_m[d]; rd_known[d] = 1'b1; end
      end else if (e.we) begin
        mem_m[key] = e.wdata;
      end else if (mem_m.exists(key)) begin
        last_rd[d] = mem_m[key]; rd_known[d] = 1'b1;
      end else begin
        rd_known[d] = 1'b0;
      end
    end
    chk("ready", d, 16'(ready_o[d]), 16'(exp_ready));
    chk("busy", d, 16'(busy_o[d]), 16'(exp_busy));
    chk("disp_valid", d, 16'(dv_o[d]), 16'(exp_dv));
    chk("disp_data", d, dd_o[d], ddr_m[d]);
    if (rd_known[d]) chk("rdata", d, rdata_o[d], last_rd[d]);
  endtask

  initial begin
    forever begin
      @(posedge Clk);
      #1;
      for (int d = 0; d < 2; d++) check_dut(d);
    end
  end

  task automatic do_reset(int n);
    reset = 1'b1;
    for (int d = 0; d < 2; d++) begin
      mem_en_i[d] = 1'b0;
      q[d].delete();
      ddr_m[d]    = '0;
      last_rd[d]  = '0;
      rd_known[d] = 1'b1;
    end
    repeat (n) @(posedge Clk);
    #2;
    reset = 1'b0;
  endtask

  // Issue one request; returns in the ready cycle with mem_en = hold.
  task automatic req(int d, bit w, logic [15:0] a, logic [15:0] wd, bit hold);
    exp_t e;
    mem_en_i[d] = 1'b1; we_i[d] = w; addr_i[d] = a; wdata_i[d] = wd;
    e.we = w; e.addr = a; e.wdata = wd; e.acc = cyc + 1; e.due = cyc + 1 + WC[d];
    q[d].push_back(e);
    if (w) wl[d].push_back(a);
    @(posedge Clk); #2;
    for (int i = 0; i < WC[d]; i++) begin
      mem_en_i[d] = 1'($urandom); we_i[d] = 1'($urandom);
      addr_i[d] = 16'($urandom); wdata_i[d] = 16'($urandom);
      @(posedge Clk); #2;
    end
    mem_en_i[d] = hold;
  endtask

  task automatic idle(int n);
    repeat (n) begin
      for (int d = 0; d < 2; d++) begin
        addr_i[d] = 16'($urandom); wdata_i[d] = 16'($urandom); we_i[d] = 1'($urandom);
      end
      @(posedge Clk); #2;
    end
  endtask

  task automatic random_phase(int d, int n);
    int          r;
    logic [15:0] a, m;
    for (int i = 0; i < n; i++) begin
      r = $urandom_range(0, 9);
      m = 16'((1 << AW[d]) - 1);
      if (r == 0) req(d, 1'($urandom), 16'hFE04, 16'($urandom), 1'b0);
      else if (r == 1) req(d, 1'($urandom), 16'hFE06, 16'($urandom), 1'b0);
      else if (r < 6) req(d, 1'b1, 16'($urandom), 16'($urandom), 1'b0);
      else begin
        a = 16'($urandom);
        if (wl[d].size() > 0) a = (a & ~m) | (wl[d][$urandom_range(0, wl[d].size() - 1)] & m);
        req(d, 1'b0, a, 16'($urandom), ($urandom_range(0, 3) == 0) && (i != n - 1));
      end
      if (mem_en_i[d] == 1'b0) idle($urandom_range(0, 2));
    end
    mem_en_i[d] = 1'b0;
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      mem_en_i[d] = 1'b0; we_i[d] = 1'b0; addr_i[d] = '0; wdata_i[d] = '0;
    end
    do_reset(2);
    idle(5);

    // Write then read back with three wait states
    req(0, 1'b1, 16'h3000, 16'h1234, 1'b0); idle(1);
    req(0, 1'b0, 16'h3000, 16'h0000, 1'b0); idle(1);
    // Aliasing modulo 2^10
    req(0, 1'b1, 16'h0005, 16'hBEEF, 1'b0); idle(1);
    req(0, 1'b0, 16'h0405, 16'h0000, 1'b0); idle(1);
    // Display registers never touch RAM
    req(0, 1'b1, 16'h0206, 16'h7777, 1'b0); idle(1);
    req(0, 1'b1, 16'hFE06, 16'h0041, 1'b0); idle(1);
    req(0, 1'b0, 16'h0206, 16'h0000, 1'b0); idle(1);
    req(0, 1'b1, 16'hFE04, 16'hDEAD, 1'b0); idle(1);
    req(0, 1'b0, 16'hFE04, 16'h0000, 1'b0); idle(1);
    req(0, 1'b0, 16'hFE06, 16'h0000, 1'b0); idle(1);
    req(0, 1'b1, 16'h0006, 16'h1111, 1'b0); idle(1);
    req(0, 1'b0, 16'h0206, 16'h0000, 1'b0); idle(1);

    // Reset during WAIT drops the pending write
    req(0, 1'b1, 16'h0010, 16'h5555, 1'b0); idle(1);
    begin
      exp_t e;
      mem_en_i[0] = 1'b1; we_i[0] = 1'b1; addr_i[0] = 16'h0010; wdata_i[0] = 16'hAAAA;
      e.we = 1'b1; e.addr = 16'h0010; e.wdata = 16'hAAAA; e.acc = cyc + 1; e.due = cyc + 1 + WC[0];
      q[0].push_back(e);
      @(posedge Clk); #2;
      mem_en_i[0] = 1'b0;
      @(posedge Clk); #2;
      do_reset(1);
    end
    idle(4);
    req(0, 1'b0, 16'h0010, 16'h0000, 1'b0); idle(1);

    random_phase(0, 40);
    idle(2);

    // Zero wait states, mem_en held: one completion per cycle, never busy
    req(1, 1'b1, 16'h0001, 16'h0C0C, 1'b0); idle(1);
    req(1, 1'b0, 16'h0001, 16'h0000, 1'b1);
    req(1, 1'b0, 16'h0001, 16'h0000, 1'b1);
    req(1, 1'b0, 16'h0001, 16'h0000, 1'b1);
    req(1, 1'b0, 16'h0001, 16'h0000, 1'b0); idle(1);
    req(1, 1'b1, 16'h0041, 16'h0E0E, 1'b1);
    req(1, 1'b0, 16'h0001, 16'h0000, 1'b0); idle(1);
    random_phase(1, 40);
    idle(2);

    // Three wait states, mem_en held: completions WAIT_CYCLES+1 apart
    req(0, 1'b0, 16'h3000, 16'h0000, 1'b1);
    req(0, 1'b0, 16'h0405, 16'h0000, 1'b1);
    req(0, 1'b0, 16'hFE04, 16'h0000, 1'b0);
    idle(6);

    for (int d = 0; d < 2; d++) chk("drain", d, 16'(q[d].size()), 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/lc3_mem_responder.md
Name: lc3_mem_responder

Overview:
- Memory-side responder for the LC-3 datapath's MAR/MDR memory interface.
- Accepts one read or write request at a time from the CPU control FSM and inserts a configurable number of wait states.
- Completes the request with a one-cycle `ready` (LC-3 "R") pulse.
- Backs a small single-port RAM and implements the display registers DSR/DDR as memory-mapped I/O.

Parameters:
- ADDR_W, 10: RAM address width; RAM depth is 2^ADDR_W words of 16 bits. Legal range 4..16.
- WAIT_CYCLES, 3: wait states between request acceptance and response. Legal range 0..15.

Ports:
- Clk  in  1  clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high.
- mem_en  in  1  request valid (LC-3 MIO_EN).
- we  in  1  1 = write, 0 = read (LC-3 R.W).
- addr  in  16  word address (from MAR).
- wdata  in  16  write data (from MDR).
- rdata  out  16  read data; valid while ready=1.
- ready  out  1  one-cycle completion pulse (LC-3 R).
- busy  out  1  high while a request is in its wait phase.
- disp_valid  out  1  one-cycle pulse when DDR is written.
- disp_data  out  16  value written to DDR.

Behaviour:
- Reset (sync, reset=1 at an edge):
  - state=IDLE; ready=0, rdata=0x0000, busy=0, disp_valid=0, disp_data=0x0000; DDR shadow=0x0000.
  - RAM contents are not reset.
  - Reset mid-request abandons the request: a pending write is dropped and no ready pulse is produced.
- State machine: IDLE, WAIT.
  - IDLE: at edge k with mem_en=1, latch we/addr/wdata.
    - If WAIT_CYCLES=0, complete at edge k and stay in IDLE.
    - Otherwise load cnt=WAIT_CYCLES-1 and go to WAIT.
  - WAIT: mem_en, we, addr and wdata are ignored (latched copies are used).
    - cnt>0: decrement.
    - cnt=0: complete at this edge, return to IDLE.
- Latency: ready is high during the cycle after edge k+WAIT_CYCLES; the pulse is registered and exactly one cycle wide.
- busy = (state==WAIT).
- Back-to-back requests:
  - If mem_en is still high in the cycle after the ready pulse, IDLE accepts a new request using the current inputs.
  - Successive completions are therefore WAIT_CYCLES+1 cycles apart.
  - The requester must drop mem_en in the ready cycle to avoid a repeat.
- Completion actions, by latched address:
  - 0xFE04 (DSR), read: rdata=0x8000 (display always ready). Write: ignored; ready still pulses.
  - 0xFE06 (DDR), write: DDR shadow=wdata, disp_data=wdata, disp_valid=1 for exactly the ready cycle. Read: rdata=DDR shadow.
  - Any other address, RAM index addr[ADDR_W-1:0]: upper bits are ignored, so addresses alias modulo 2^ADDR_W.
    - Write: RAM[index]=wdata.
    - Read: rdata=RAM[index].
  - DSR/DDR accesses never touch RAM.
- rdata updates only on read completions and holds its value otherwise, including across write completions.
- RAM is synchronous read. The RAM address is the addr input in IDLE and the latched address in WAIT, so read data is registered at the completion edge and meets the timing above for WAIT_CYCLES=0.
- A write followed by a read to the same index returns the new data.

Decomposition:
- Package lc3_mem_pkg:
  - state enum (IDLE, WAIT).
  - constants DSR_ADDR=16'hFE04, DDR_ADDR=16'hFE06, DSR_READY=16'h8000.
- Sub-module lc3_ram_sp, parameters ADDR_W and width 16:
  - ports: Clk, en, we, addr, wdata, rdata.
  - synchronous write and synchronous read, one access per cycle, no reset.

Test Plan:
1. Reset held 2 cycles, then idle 5 cycles -> ready=0, busy=0, rdata=0x0000, disp_valid=0 throughout.
2. WAIT_CYCLES=3: write 0x1234 to 0x3000, mem_en dropped in the ready cycle.
   - busy=1 for 3 cycles; ready pulses once, after edge k+3.
   - Read of 0x3000 then returns rdata=0x1234 with ready, 4 cycles after acceptance.
3. ADDR_W=10: write 0xBEEF to 0x0005, then read 0x0405 -> rdata=0xBEEF (alias).
4. Write 0x0041 to 0xFE06 -> disp_valid=1 for one cycle with disp_data=0x0041.
   - Read 0x0206 -> unchanged prior RAM value.
   - Read 0xFE04 -> 0x8000; read 0xFE06 -> 0x0041.
5. Write 0x5555 to 0x0010 completes. Then write 0xAAAA to 0x0010 with reset asserted during WAIT.
   - No ready pulse; all outputs return to reset values.
   - Read 0x0010 -> 0x5555.
6. WAIT_CYCLES=0: mem_en held high for 4 cycles reading 0x0001 -> ready high 4 consecutive cycles, busy stays 0.
   - WAIT_CYCLES=3, mem_en held high -> ready pulses 4 cycles apart.
